// File: rtl/kth_order_egk_decoder_pkg.sv
// Shared definitions for the k-th order Exp-Golomb binarizer and decoder.
package egk_pkg;

  // Decoder control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    SUFFIX = 2'd2,
    DONE   = 2'd3
  } egk_state_t;

  // Width needed to hold an EGk order in the range 0..symbol_bits
  function automatic int k_int_bits(input int symbol_bits);
    return $clog2(symbol_bits) + 1;
  endfunction

  // Longest legal bin string for a given magnitude width and starting order
  function automatic int max_code_len(input int symbol_bits, input int k);
    return 2 * symbol_bits + 1 - k;
  endfunction

endpackage

// File: rtl/kth_order_egk_decoder.sv
// Bit-serial k-th order Exp-Golomb decoder. Consumes a unary prefix and a
// k-bit suffix MSB-first and reconstructs the encoded unsigned magnitude,
// together with the number of bins consumed and an error flag.
module kth_order_egk_decoder
  import egk_pkg::*;
#(
  parameter int SYMBOL_BITS = 8,
  parameter int MAX_BITS    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             K,
  input  logic                   bit_valid,
  input  logic                   bit_in,
  output logic                   bit_ready,
  output logic                   sym_valid,
  input  logic                   sym_ready,
  output logic [SYMBOL_BITS-1:0] symbolVal,
  output logic [MAX_BITS-1:0]    code_len,
  output logic                   err,
  output logic                   busy
);

  localparam int K_INT_BITS = k_int_bits(SYMBOL_BITS);
  localparam logic [K_INT_BITS-1:0] LP_K_MAX = K_INT_BITS'(SYMBOL_BITS);

  egk_state_t             r_state;
  logic [K_INT_BITS-1:0]  r_k;
  logic [K_INT_BITS-1:0]  r_cnt;
  logic [SYMBOL_BITS-1:0] r_base;
  logic [SYMBOL_BITS-1:0] r_suffix;
  logic [MAX_BITS-1:0]    r_code_len;
  logic [SYMBOL_BITS-1:0] r_sym;
  logic                   r_err;
  logic                   r_sym_valid;

  logic                   w_k_too_big;
  logic                   w_xfer;
  logic [MAX_BITS-1:0]    w_len_inc;
  logic [SYMBOL_BITS-1:0] w_suffix_next;
  logic [SYMBOL_BITS-1:0] w_base_inc;
  logic [SYMBOL_BITS:0]   w_sum;

  // Handshake and status decoded straight from the state register
  assign bit_ready = (r_state == PREFIX) || (r_state == SUFFIX);
  assign busy      = bit_ready;
  assign w_xfer    = bit_valid && bit_ready;

  // Datapath helpers: order check, saturating length, prefix weight, final sum
  assign w_k_too_big   = (32'(K) > 32'(SYMBOL_BITS));
  assign w_len_inc     = (&r_code_len) ? r_code_len : r_code_len + MAX_BITS'(1);
  assign w_base_inc    = r_base + (SYMBOL_BITS'(1) << r_k);
  assign w_suffix_next = {r_suffix[SYMBOL_BITS-2:0], bit_in};
  assign w_sum         = {1'b0, r_base} + {1'b0, w_suffix_next};

  // Control FSM with registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_cnt       <= '0;
      r_base      <= '0;
      r_suffix    <= '0;
      r_code_len  <= '0;
      r_sym       <= '0;
      r_err       <= 1'b0;
      r_sym_valid <= 1'b0;
    end else if (start) begin
      // A new decode always wins; any partial or pending result is dropped
      r_base     <= '0;
      r_suffix   <= '0;
      r_code_len <= '0;
      r_cnt      <= '0;
      r_sym      <= '0;
      if (w_k_too_big) begin
        r_state     <= DONE;
        r_k         <= '0;
        r_err       <= 1'b1;
        r_sym_valid <= 1'b1;
      end else begin
        r_state     <= PREFIX;
        r_k         <= K_INT_BITS'(K);
        r_err       <= 1'b0;
        r_sym_valid <= 1'b0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_sym_valid <= 1'b0;
        end

        PREFIX: begin
          if (w_xfer) begin
            r_code_len <= w_len_inc;
            if (bit_in) begin
              if (r_k == LP_K_MAX) begin
                // Prefix longer than any magnitude of this width can need
                r_err       <= 1'b1;
                r_sym       <= r_base;
                r_sym_valid <= 1'b1;
                r_state     <= DONE;
              end else begin
                r_base <= w_base_inc;
                r_k    <= r_k + K_INT_BITS'(1);
              end
            end else if (r_k == '0) begin
              // Zero-length suffix: the prefix alone determines the value
              r_sym       <= r_base;
              r_sym_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_cnt   <= r_k;
              r_state <= SUFFIX;
            end
          end
        end

        SUFFIX: begin
          if (w_xfer) begin
            r_code_len <= w_len_inc;
            r_suffix   <= w_suffix_next;
            r_cnt      <= r_cnt - K_INT_BITS'(1);
            if (r_cnt == K_INT_BITS'(1)) begin
              // Carry out of the sum means the code cannot be represented
              r_sym       <= w_sum[SYMBOL_BITS-1:0];
              r_err       <= w_sum[SYMBOL_BITS];
              r_sym_valid <= 1'b1;
              r_state     <= DONE;
            end
          end
        end

        DONE: begin
          if (sym_ready) begin
            r_sym_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_sym_valid <= 1'b0;
        end
      endcase
    end
  end

  assign sym_valid = r_sym_valid;
  assign symbolVal = r_sym;
  assign code_len  = r_code_len;
  assign err       = r_err;

endmodule

// File: tb/tb_kth_order_egk_decoder.sv
// Self-checking bench for kth_order_egk_decoder: directed codes plus an
// encoder loopback over all magnitudes and orders.
module tb_kth_order_egk_decoder;

  localparam int SB = 8;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    K = 4'd0;
  logic          bit_valid = 1'b0;
  logic          bit_in = 1'b0;
  logic          sym_ready = 1'b0;
  logic          bit_ready;
  logic          sym_valid;
  logic [SB-1:0] symbolVal;
  logic [MB-1:0] code_len;
  logic          err;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected externally visible behaviour, advanced by the stimulus process
  bit exp_busy  = 1'b0;
  bit exp_valid = 1'b0;
  bit exp_err   = 1'b0;
  int exp_val   = 0;
  int exp_len   = 0;
  bit in_done   = 1'b0;

  always #5 clk = ~clk;

  kth_order_egk_decoder #(.SYMBOL_BITS(SB), .MAX_BITS(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .K         (K),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .bit_ready (bit_ready),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .symbolVal (symbolVal),
    .code_len  (code_len),
    .err       (err),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference decoder: walks the bin string with integer arithmetic
  function automatic void model_decode(input int kk, input logic [63:0] bits, input int nb,
                                       output int val, output int len, output bit e);
    int k;
    int base;
    int suf;
    int i;
    int sum;
    k = kk; base = 0; suf = 0; i = 0;
    val = 0; len = 0; e = 1'b0;
    if (kk > SB) begin
      e = 1'b1;
      return;
    end
    while (i < nb) begin
      if (bits[nb-1-i]) begin
        i++;
        if (k == SB) begin
          e = 1'b1; val = base; len = i;
          return;
        end
        base += (1 << k);
        k++;
      end else begin
        i++;
        break;
      end
    end
    for (int j = 0; j < k; j++) begin
      suf = suf * 2 + int'(bits[nb-1-i]);
      i++;
    end
    sum = base + suf;
    val = sum % (1 << SB);
    e   = (sum >= (1 << SB));
    len = i;
  endfunction

  // Reference EGk binarizer for the loopback sweep
  function automatic void encode(input int kk, input int v, output logic [63:0] bits, output int nb);
    int k;
    int r;
    k = kk; r = v; bits = '0; nb = 0;
    while (r >= (1 << k)) begin
      bits = {bits[62:0], 1'b1}; nb++;
      r -= (1 << k); k++;
    end
    bits = {bits[62:0], 1'b0}; nb++;
    for (int j = k - 1; j >= 0; j--) begin
      bits = {bits[62:0], 1'(r >> j)}; nb++;
    end
  endfunction

  // Per-cycle comparison of the DUT against the expected behaviour
  always @(negedge clk) begin
    check("bit_ready", 32'(bit_ready), 32'(exp_busy));
    check("busy", 32'(busy), 32'(exp_busy));
    check("sym_valid", 32'(sym_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("symbolVal", 32'(symbolVal), 32'(exp_val));
      check("code_len", 32'(code_len), 32'(exp_len));
      check("err", 32'(err), 32'(exp_err));
    end
  end

  // One decode: start (optionally with a result handshake), then feed bins
  task automatic run_decode(input int kk, input logic [63:0] bits, input int nb,
                            input int stall_at, input int stall_n,
                            input int feed_limit, input bit bin_with_start);
    int v;
    int l;
    bit e;
    int nfeed;
    model_decode(kk, bits, nb, v, l, e);
    start = 1'b1; K = 4'(kk); sym_ready = in_done;
    bit_valid = bin_with_start; bit_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; sym_ready = 1'b0; bit_valid = 1'b0; in_done = 1'b0;
    if (kk > SB) begin
      exp_busy = 1'b0; exp_valid = 1'b1;
      exp_val = v; exp_len = l; exp_err = e; in_done = 1'b1;
      $display("decode K=%0d -> val=%0d len=%0d err=%0d", kk, v, l, e);
      return;
    end
    exp_busy = 1'b1; exp_valid = 1'b0;
    nfeed = (feed_limit >= 0 && feed_limit < l) ? feed_limit : l;
    for (int i = 0; i < nfeed; i++) begin
      if (i == stall_at) begin
        bit_valid = 1'b0;
        repeat (stall_n) begin
          bit_in = ~bit_in;
          @(posedge clk); #1;
        end
      end
      bit_valid = 1'b1; bit_in = bits[nb-1-i];
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
    if (nfeed == l) begin
      exp_busy = 1'b0; exp_valid = 1'b1;
      exp_val = v; exp_len = l; exp_err = e; in_done = 1'b1;
      $display("decode K=%0d -> val=%0d len=%0d err=%0d", kk, v, l, e);
    end else begin
      $display("decode K=%0d fed %0d of %0d bins", kk, nfeed, l);
    end
  endtask

  task automatic release_result();
    sym_ready = 1'b1;
    @(posedge clk); #1;
    sym_ready = 1'b0; exp_valid = 1'b0; in_done = 1'b0;
  endtask

  task automatic check_result(input string name, input int v, input int l, input bit e);
    check({name, "_val"}, 32'(symbolVal), 32'(v));
    check({name, "_len"}, 32'(code_len), 32'(l));
    check({name, "_err"}, 32'(err), 32'(e));
  endtask

  initial begin
    int v;
    int l;
    bit e;
    logic [63:0] bits;
    int nb;

    // Pin the reference functions to hand-computed values
    model_decode(2, 64'b10101, 5, v, l, e);
    check("model_k2", 32'(v), 32'd9);
    check("model_k2_len", 32'(l), 32'd5);
    model_decode(0, 64'b101, 3, v, l, e);
    check("model_k0", 32'(v), 32'd2);
    model_decode(0, 64'h1FF, 9, v, l, e);
    check("model_ones", 32'(v), 32'd255);
    check("model_ones_err", 32'(e), 32'd1);
    encode(2, 9, bits, nb);
    check("enc_k2_bits", bits[31:0], 32'b10101);
    check("enc_k2_len", 32'(nb), 32'd5);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_sym_valid", 32'(sym_valid), 32'd0);
    check("rst_bit_ready", 32'(bit_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_symbolVal", 32'(symbolVal), 32'd0);
    check("rst_code_len", 32'(code_len), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Bins offered while idle must be ignored
    bit_valid = 1'b1; bit_in = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    bit_valid = 1'b0;

    run_decode(0, 64'b0, 1, -1, 0, -1, 1'b0);
    check_result("k0_zero", 0, 1, 1'b0);
    release_result();

    run_decode(0, 64'b101, 3, -1, 0, -1, 1'b0);
    check_result("k0_101", 2, 3, 1'b0);
    release_result();

    run_decode(2, 64'b10101, 5, -1, 0, -1, 1'b0);
    check_result("k2_10101", 9, 5, 1'b0);

    // Same code with a 3-cycle bit_valid gap, started back-to-back
    run_decode(2, 64'b10101, 5, 2, 3, -1, 1'b0);
    check_result("k2_stall", 9, 5, 1'b0);
    release_result();

    run_decode(0, 64'h1FF, 9, -1, 0, -1, 1'b0);
    check_result("ones", 255, 9, 1'b1);
    release_result();

    run_decode(9, 64'b0, 0, -1, 0, -1, 1'b0);
    check_result("k9", 0, 0, 1'b1);
    release_result();

    run_decode(0, 64'b11111111_0_00000001, 17, -1, 0, -1, 1'b0);
    check_result("ovf", 0, 17, 1'b1);
    release_result();

    // Abort a K=1 decode after two bins; restart carries an unused bin
    run_decode(1, 64'b1011, 4, -1, 0, 2, 1'b0);
    run_decode(1, 64'b1000, 4, -1, 0, -1, 1'b1);
    check_result("abort_new", 2, 4, 1'b0);

    // Hold the result, then start the next decode with the handshake
    repeat (5) begin @(posedge clk); #1; end
    check_result("hold", 2, 4, 1'b0);
    run_decode(3, 64'b0000, 4, -1, 0, -1, 1'b0);
    check_result("k3_zero", 0, 4, 1'b0);
    release_result();

    // Loopback sweep of every magnitude for every legal order
    for (int kk = 0; kk <= SB; kk++) begin
      for (int val = 0; val < (1 << SB); val++) begin
        encode(kk, val, bits, nb);
        model_decode(kk, bits, nb, v, l, e);
        check("loop_model_val", 32'(v), 32'(val));
        check("loop_model_len", 32'(l), 32'(nb));
        check("loop_len_bound", 32'(nb <= egk_pkg::max_code_len(SB, kk)), 32'd1);
        run_decode(kk, bits, nb, -1, 0, -1, 1'b0);
        check("loop_dut_val", 32'(symbolVal), 32'(val));
      end
    end
    release_result();
    repeat (2) begin @(posedge clk); #1; end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kth_order_egk_decoder.md
# kth_order_egk_decoder

Bit-serial k-th order Exp-Golomb decoder, the receive-side counterpart of the team's k-th order EGk binarizer. It consumes a prefix/suffix EGk bin string MSB-first over a valid/ready bit interface and reconstructs the unsigned magnitude that was encoded. It also reports the number of bins consumed. It sits in the debinarization path, ahead of the sign and context handling.

## Interface
- SYMBOL_BITS, 8, width of the decoded magnitude.
- MAX_BITS, 16, width of the code_len counter.
- Derived constant: K_INT_BITS = $clog2(SYMBOL_BITS)+1.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  begin a new decode; samples K; priority over everything except rst.
- K  in  4  EGk order, sampled only on start.
- bit_valid  in  1  bit_in is valid.
- bit_in  in  1  next bin, MSB-first.
- bit_ready  out  1  decoder accepts a bin this cycle.
- sym_valid  out  1  result valid; held until accepted.
- sym_ready  in  1  downstream accepts the result.
- symbolVal  out  SYMBOL_BITS  decoded magnitude.
- code_len  out  MAX_BITS  bins consumed for this symbol.
- err  out  1  malformed or overflowing code; qualified by sym_valid.
- busy  out  1  high in PREFIX or SUFFIX.

## Operation
- States:
  - IDLE: waits for start.
  - PREFIX: reads unary prefix bins.
  - SUFFIX: reads k suffix bins.
  - DONE: presents the result.
- Bin transfer occurs when bit_valid && bit_ready. bit_ready is 1 exactly in PREFIX and SUFFIX, combinationally from state.
- start, in any state:
  - Loads k = K, base = 0, suffix = 0, code_len = 0, and clears err.
  - Goes to PREFIX.
  - If K > SYMBOL_BITS: goes to DONE with err = 1, symbolVal = 0, code_len = 0.
- PREFIX, on each transferred bin (code_len increments on every transferred bin):
  - bin 1 with k < SYMBOL_BITS: base += 2^k, then k += 1.
  - bin 1 with k == SYMBOL_BITS: err = 1, go to DONE, symbolVal = base.
  - bin 0 with k == 0: go to DONE, symbolVal = base.
  - bin 0 with k > 0: load cnt = k, go to SUFFIX.
- SUFFIX, on each transferred bin:
  - suffix = (suffix << 1) | bin, and cnt -= 1.
  - When cnt reaches 0: go to DONE.
  - Result is base + suffix, computed in SYMBOL_BITS+1 bits. If the carry bit is set, err = 1 and symbolVal takes the truncated low bits.
- DONE:
  - sym_valid = 1, with symbolVal, code_len and err held stable.
  - On sym_ready, go to IDLE.
- A start arriving together with sym_ready in DONE: start wins, and the result counts as consumed.
- Mid-decode start: the partial decode is discarded without any sym_valid pulse. A bin presented in the same cycle as start is not consumed.
- bit_valid low stalls the FSM with no state change. Bins offered outside PREFIX/SUFFIX are ignored.

## Timing
- Reset values: state IDLE; bit_ready, sym_valid, err and busy all 0; symbolVal = 0; code_len = 0.
- start in cycle 0 moves to PREFIX in cycle 1. The first bin can transfer in cycle 1.
- For an N-bin code with no stalls, bins transfer in cycles 1..N and sym_valid rises in cycle N+1. Each stall cycle adds one.
- Back-to-back decodes: start may be asserted in the same cycle as the DONE handshake, so the next bin is accepted in the following cycle.
- All outputs are registered except bit_ready and busy, which are decoded from the state register.
- The code_len counter saturates at 2^MAX_BITS-1. This cannot occur for legal SYMBOL_BITS/MAX_BITS pairs.

## Structure
- Package egk_pkg holds:
  - the state enum (IDLE, PREFIX, SUFFIX, DONE);
  - a function computing K_INT_BITS from SYMBOL_BITS;
  - a function computing the maximum legal code length, 2*SYMBOL_BITS+1 - K.
- The binarizer is to import the same package.
- The block is a single module with no sub-module. The datapath (base accumulator, suffix shifter, adder) is too small to justify a split.

## Test plan
- K=0, bins "0": sym_valid in cycle 2 with symbolVal=0, code_len=1, err=0.
- K=0, bins "1,0,1": symbolVal=2, code_len=3. K=2, bins "1,0,1,0,1": symbolVal=9, code_len=5.
- K=2, bins "1,0,1,0,1" with bit_valid dropped for 3 cycles between bins: symbolVal=9, and sym_valid is delayed exactly 3 cycles.
- SYMBOL_BITS=8, K=0, nine consecutive "1" bins: err=1, symbolVal=255, code_len=9, with no suffix read. Separately, K=9: immediate DONE with err=1.
- start reasserted after two bins of a K=1 decode: no sym_valid for the aborted decode. The new code is decoded correctly.
- sym_ready held low for 5 cycles in DONE: outputs stay stable and bit_ready=0. Then start+sym_ready in the same cycle begins the next decode with no gap cycle.
- Loopback: every magnitude 0..255 for K=0..8 through the binarizer into this block. symbolVal equals the input magnitude and code_len equals the binarizer's code_len.
